cam_cmd_ctrl: RTL and testbench
===============================

Name: cam_cmd_ctrl

Overview:
Command sequencer that acts as the initiator for the 8-entry x 4-bit CAM file. It accepts host commands over a valid/ready handshake and drives the CAM lookup, write and init pins. It samples the CAM's valid, minimum-address and maximum-address outputs, then returns a registered response over a second valid/ready handshake. It adds a multi-cycle REPLACE_ALL operation that loops lookup/write until no entry matches.

Parameters:
MAX_ITER, 4, hard cap on write iterations per REPLACE_ALL (8 entries / 2 writes per iteration)

Ports:
clk  in  1  clock, all state changes on posedge
reset  in  1  synchronous, active-high
cmd_valid  in  1  host command present
cmd_ready  out  1  controller can accept a command
cmd_op  in  2  00 SEARCH, 01 REPLACE, 10 REPLACE_ALL, 11 INIT
cmd_key  in  4  lookup key
cmd_data  in  4  replacement data
rsp_valid  out  1  response present
rsp_ready  in  1  host consumes response
rsp_hit  out  1  first lookup matched
rsp_min  out  3  first-lookup minimum matching address
rsp_max  out  3  first-lookup maximum matching address
rsp_count  out  4  number of CAM entries written (0..8)
cam_init  out  1  to CAM init (loads entry i with 8+i)
cam_lookup  out  4  to CAM D_Lookup
cam_setD  out  1  to CAM setD
cam_newD  out  4  to CAM newD
cam_valid  in  1  from CAM: some entry matches cam_lookup (combinational)
cam_minAddr  in  3  from CAM
cam_maxAddr  in  3  from CAM

Behaviour:
- Reset state: IDLE. Reset forces every output to 0, including cmd_ready while reset is high. Reset does not re-initialise CAM contents; only INIT does.
- States: IDLE, INIT, LOOK, WRITE, RESP.
- IDLE:
  - cmd_ready=1.
  - Command accepted when cmd_valid&cmd_ready at a posedge.
  - On accept, latch op/key/data, clear the iteration counter and rsp_count, and set a first-lookup flag.
  - Next state is INIT if op=11, otherwise LOOK.
- INIT: cam_init=1 for exactly one cycle. Next state RESP with hit=0, min=0, max=0, count=0.
- LOOK:
  - cam_lookup = latched key. cam_lookup holds the latched key in LOOK and WRITE; it is 0 elsewhere.
  - At end of cycle, sample cam_valid/cam_minAddr/cam_maxAddr into internal registers.
  - If first-lookup, also load rsp_hit/rsp_min/rsp_max, then clear first-lookup.
  - Transition rules:
    - SEARCH -> RESP.
    - REPLACE: hit -> WRITE, miss -> RESP.
    - REPLACE_ALL: hit and iteration<MAX_ITER and data!=key -> WRITE, else RESP.
    - REPLACE_ALL with data==key performs no writes (count 0); this prevents an endless loop.
- WRITE:
  - cam_setD=1 and cam_newD = latched data for one cycle; the key is still held, so the CAM writes min and max entries at the closing edge.
  - rsp_count += 1 if sampled min==max, else += 2. Iteration counter += 1.
  - Next state: REPLACE -> RESP; REPLACE_ALL -> LOOK.
- RESP:
  - rsp_valid=1. Response fields are held stable until rsp_valid&rsp_ready, then the next state is IDLE.
  - cmd_ready=0 outside IDLE; no command overlap.
- Latency, with accept at edge T:
  - SEARCH: rsp_valid from cycle T+2.
  - REPLACE hit: T+3; REPLACE miss: T+2.
  - INIT: T+2.
  - REPLACE_ALL with N write iterations: T+2+2N.
- cam_setD is never asserted except in WRITE, and is 0 whenever cam_valid was low in the preceding LOOK.
- Reset mid-operation (any state): next cycle IDLE, all outputs 0. No cam_setD or cam_init in the cycle after reset is sampled. A pending response is discarded.
- cam_newD is 0 outside WRITE.

Test Plan:
- INIT, then SEARCH key=4'hA -> cam_init high 1 cycle. SEARCH response at T+2: hit=1, min=2, max=2, count=0, cam_setD never high.
- After INIT, SEARCH key=4'h0 -> hit=0, min=0, max=0, count=0 at T+2. REPLACE key=0 data=5 -> response at T+2, no cam_setD, CAM unchanged.
- After INIT, REPLACE key=4'hA data=4'h3 -> cam_setD high at T+2 with newD=3. Response at T+3: hit=1, min=2, max=2, count=1. Follow-up SEARCH 3 -> min=2, max=2.
- After INIT, REPLACE 9->8 and C->8 (entries 0,1,4 = 8), then REPLACE_ALL key=8 data=5 -> sequence LOOK,WRITE,LOOK,WRITE,LOOK,RESP. Response at T+6: hit=1, min=0, max=4, count=3. SEARCH 8 then misses.
- REPLACE_ALL key=8 data=8 after INIT -> hit=1, min=0, max=0, count=0, no cam_setD.
- Backpressure: hold rsp_ready=0 for 3 cycles in RESP -> rsp fields stable, cmd_ready=0, and cmd_valid is ignored. Separately, assert reset during WRITE of a REPLACE_ALL -> IDLE next cycle, rsp_valid=0, no further cam_setD.

Source files
------------

// File: rtl/cam_cmd_ctrl_if.sv
// Host command/response handshakes and CAM pin bundle for cam_cmd_ctrl.
//   slave  : the controller side (accepts commands, drives CAM pins)
//   master : the host + CAM side (issues commands, returns CAM match results)
// Signals:
//   cmd_valid/cmd_ready/cmd_op/cmd_key/cmd_data : command handshake
//   rsp_valid/rsp_ready/rsp_hit/rsp_min/rsp_max/rsp_count : response handshake
//   cam_init/cam_lookup/cam_setD/cam_newD : controller -> CAM
//   cam_valid/cam_minAddr/cam_maxAddr     : CAM -> controller
interface cam_cmd_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_key;
    logic [3:0] cmd_data;

    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_hit;
    logic [2:0] rsp_min;
    logic [2:0] rsp_max;
    logic [3:0] rsp_count;

    logic       cam_init;
    logic [3:0] cam_lookup;
    logic       cam_setD;
    logic [3:0] cam_newD;
    logic       cam_valid;
    logic [2:0] cam_minAddr;
    logic [2:0] cam_maxAddr;

    modport slave (
        input  cmd_valid, cmd_op, cmd_key, cmd_data,
        output cmd_ready,
        output rsp_valid, rsp_hit, rsp_min, rsp_max, rsp_count,
        input  rsp_ready,
        output cam_init, cam_lookup, cam_setD, cam_newD,
        input  cam_valid, cam_minAddr, cam_maxAddr
    );

    modport master (
        output cmd_valid, cmd_op, cmd_key, cmd_data,
        input  cmd_ready,
        input  rsp_valid, rsp_hit, rsp_min, rsp_max, rsp_count,
        output rsp_ready,
        input  cam_init, cam_lookup, cam_setD, cam_newD,
        output cam_valid, cam_minAddr, cam_maxAddr
    );
endinterface

// File: rtl/cam_cmd_ctrl.sv
// Command sequencer driving an 8-entry x 4-bit CAM.
// Accepts SEARCH / REPLACE / REPLACE_ALL / INIT commands, drives the CAM
// lookup/write/init pins, and returns a registered response holding the
// first-lookup result plus the number of CAM entries written.
// Ports:
//   clk   : clock, all state changes on posedge
//   reset : synchronous, active-high; clears state and all outputs
//   bus   : cam_cmd_ctrl_if.slave (command, response and CAM pins)
module cam_cmd_ctrl #(
    parameter int unsigned MAX_ITER = 4
) (
    input logic           clk,
    input logic           reset,
    cam_cmd_ctrl_if.slave bus
);

    localparam int unsigned OP_W   = 2;
    localparam int unsigned KEY_W  = 4;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned ITER_W = (MAX_ITER < 2) ? 1 : $clog2(MAX_ITER + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_LOOK  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [OP_W-1:0] OP_SEARCH  = 2'b00;
    localparam logic [OP_W-1:0] OP_REPLACE = 2'b01;
    localparam logic [OP_W-1:0] OP_REPALL  = 2'b10;
    localparam logic [OP_W-1:0] OP_INIT    = 2'b11;

    // Control state
    logic [2:0]        state_q,      state_d;
    logic [OP_W-1:0]   op_q,         op_d;
    logic [KEY_W-1:0]  key_q,        key_d;
    logic [KEY_W-1:0]  data_q,       data_d;
    logic [ITER_W-1:0] iter_q,       iter_d;
    logic              first_q,      first_d;
    logic              samp_valid_q, samp_valid_d;
    logic [ADDR_W-1:0] samp_min_q,   samp_min_d;
    logic [ADDR_W-1:0] samp_max_q,   samp_max_d;

    // Registered outputs
    logic              cmd_ready_q,  cmd_ready_d;
    logic              rsp_valid_q,  rsp_valid_d;
    logic              rsp_hit_q,    rsp_hit_d;
    logic [ADDR_W-1:0] rsp_min_q,    rsp_min_d;
    logic [ADDR_W-1:0] rsp_max_q,    rsp_max_d;
    logic [CNT_W-1:0]  rsp_count_q,  rsp_count_d;
    logic              cam_init_q,   cam_init_d;
    logic [KEY_W-1:0]  cam_lookup_q, cam_lookup_d;
    logic              cam_wr_q,     cam_wr_d;
    logic [KEY_W-1:0]  cam_newd_q,   cam_newd_d;

    // Next-state and output logic; outputs are decoded from the next state
    // so that the registered pins line up with the state they belong to.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        key_d        = key_q;
        data_d       = data_q;
        iter_d       = iter_q;
        first_d      = first_q;
        samp_valid_d = samp_valid_q;
        samp_min_d   = samp_min_q;
        samp_max_d   = samp_max_q;
        rsp_hit_d    = rsp_hit_q;
        rsp_min_d    = rsp_min_q;
        rsp_max_d    = rsp_max_q;
        rsp_count_d  = rsp_count_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    op_d        = bus.cmd_op;
                    key_d       = bus.cmd_key;
                    data_d      = bus.cmd_data;
                    iter_d      = '0;
                    first_d     = 1'b1;
                    rsp_hit_d   = 1'b0;
                    rsp_min_d   = '0;
                    rsp_max_d   = '0;
                    rsp_count_d = '0;
                    state_d     = (bus.cmd_op == OP_INIT) ? S_INIT : S_LOOK;
                end
            end

            S_INIT: begin
                state_d = S_RESP;
            end

            S_LOOK: begin
                samp_valid_d = bus.cam_valid;
                samp_min_d   = bus.cam_minAddr;
                samp_max_d   = bus.cam_maxAddr;
                // Only the first lookup of a command is reported to the host.
                if (first_q) begin
                    rsp_hit_d = bus.cam_valid;
                    rsp_min_d = bus.cam_minAddr;
                    rsp_max_d = bus.cam_maxAddr;
                    first_d   = 1'b0;
                end
                case (op_q)
                    OP_REPLACE: state_d = bus.cam_valid ? S_WRITE : S_RESP;
                    // data==key would keep matching forever, so it never writes.
                    OP_REPALL:  state_d = (bus.cam_valid && (iter_q < ITER_W'(MAX_ITER))
                                           && (data_q != key_q)) ? S_WRITE : S_RESP;
                    default:    state_d = S_RESP;
                endcase
            end

            S_WRITE: begin
                // The CAM rewrites both the min and max matching entries.
                rsp_count_d = rsp_count_q + ((samp_min_q == samp_max_q) ? CNT_W'(1) : CNT_W'(2));
                iter_d      = iter_q + ITER_W'(1);
                state_d     = (op_q == OP_REPALL) ? S_LOOK : S_RESP;
            end

            S_RESP: begin
                if (rsp_valid_q && bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_ready_d  = (state_d == S_IDLE);
        rsp_valid_d  = (state_d == S_RESP);
        cam_init_d   = (state_d == S_INIT);
        cam_wr_d     = (state_d == S_WRITE);
        cam_lookup_d = ((state_d == S_LOOK) || (state_d == S_WRITE)) ? key_d : '0;
        cam_newd_d   = (state_d == S_WRITE) ? data_d : '0;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            key_q        <= '0;
            data_q       <= '0;
            iter_q       <= '0;
            first_q      <= 1'b0;
            samp_valid_q <= 1'b0;
            samp_min_q   <= '0;
            samp_max_q   <= '0;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_min_q    <= '0;
            rsp_max_q    <= '0;
            rsp_count_q  <= '0;
            cam_init_q   <= 1'b0;
            cam_lookup_q <= '0;
            cam_wr_q     <= 1'b0;
            cam_newd_q   <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            key_q        <= key_d;
            data_q       <= data_d;
            iter_q       <= iter_d;
            first_q      <= first_d;
            samp_valid_q <= samp_valid_d;
            samp_min_q   <= samp_min_d;
            samp_max_q   <= samp_max_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_hit_q    <= rsp_hit_d;
            rsp_min_q    <= rsp_min_d;
            rsp_max_q    <= rsp_max_d;
            rsp_count_q  <= rsp_count_d;
            cam_init_q   <= cam_init_d;
            cam_lookup_q <= cam_lookup_d;
            cam_wr_q     <= cam_wr_d;
            cam_newd_q   <= cam_newd_d;
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_hit    = rsp_hit_q;
    assign bus.rsp_min    = rsp_min_q;
    assign bus.rsp_max    = rsp_max_q;
    assign bus.rsp_count  = rsp_count_q;
    assign bus.cam_init   = cam_init_q;
    assign bus.cam_lookup = cam_lookup_q;
    assign bus.cam_setD   = cam_wr_q;
    assign bus.cam_newD   = cam_newd_q;

endmodule

// File: tb/tb_cam_cmd_ctrl.sv
// Self-checking bench for cam_cmd_ctrl with a behavioural 8x4 CAM.
module tb_cam_cmd_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cam_cmd_ctrl_if bus ();

    cam_cmd_ctrl #(.MAX_ITER(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural CAM: combinational match, init loads 8+i, write min & max.
    logic [3:0] mem [8];
    always_comb begin
        bus.cam_valid   = 1'b0;
        bus.cam_minAddr = 3'd0;
        bus.cam_maxAddr = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (mem[i] == bus.cam_lookup) begin
                bus.cam_valid   = 1'b1;
                bus.cam_minAddr = 3'(i);
            end
        for (int i = 0; i < 8; i++)
            if (mem[i] == bus.cam_lookup) bus.cam_maxAddr = 3'(i);
    end
    always @(posedge clk) begin
        if (bus.cam_init) begin
            for (int i = 0; i < 8; i++) mem[i] <= 4'(8 + i);
        end else if (bus.cam_setD && bus.cam_valid) begin
            mem[bus.cam_minAddr] <= bus.cam_newD;
            mem[bus.cam_maxAddr] <= bus.cam_newD;
        end
    end

    typedef struct {
        int hit; int mn; int mx; int cnt;
        int lat; int wr; int inits; int data; int acc_cyc;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic exp_t mk(int hit, int mn, int mx, int cnt, int lat, int wr, int inits, int data);
        exp_t e;
        e.hit = hit; e.mn = mn; e.mx = mx; e.cnt = cnt;
        e.lat = lat; e.wr = wr; e.inits = inits; e.data = data; e.acc_cyc = 0;
        return e;
    endfunction

    // Monitor: checks CAM pin activity and pops/compares each response.
    bit in_rsp = 0;
    int wr_cnt = 0;
    int init_cnt = 0;
    always @(negedge clk) begin
        if (reset) begin
            in_rsp = 0; wr_cnt = 0; init_cnt = 0;
        end else begin
            if (bus.cam_setD) begin
                wr_cnt++;
                if (sb.size() == 0) chk("setD_no_cmd", 1, 0);
                else chk("newD", int'(bus.cam_newD), sb[0].data);
            end else begin
                chk("newD_idle", int'(bus.cam_newD), 0);
            end
            if (bus.cam_init) init_cnt++;
            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    if (!in_rsp) chk("latency", cyc - sb[0].acc_cyc + 1, sb[0].lat);
                    chk("rsp_hit",   int'(bus.rsp_hit),   sb[0].hit);
                    chk("rsp_min",   int'(bus.rsp_min),   sb[0].mn);
                    chk("rsp_max",   int'(bus.rsp_max),   sb[0].mx);
                    chk("rsp_count", int'(bus.rsp_count), sb[0].cnt);
                    if (bus.rsp_ready) begin
                        chk("setD_cycles", wr_cnt, sb[0].wr);
                        chk("init_cycles", init_cnt, sb[0].inits);
                        void'(sb.pop_front());
                        in_rsp = 0; wr_cnt = 0; init_cnt = 0;
                    end else begin
                        in_rsp = 1;
                    end
                end
            end
        end
    end

    // Driver: present a command, push its expected response at accept.
    task automatic issue(input logic [1:0] op, input logic [3:0] key, input logic [3:0] data, input exp_t e);
        int n = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_key   = key;
        bus.cmd_data  = data;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            chk("accept_timeout", 0, 1);
            bus.cmd_valid = 1'b0;
            return;
        end
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("rsp_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic cmd(input logic [1:0] op, input logic [3:0] key, input logic [3:0] data, input exp_t e);
        issue(op, key, data, e);
        wait_idle();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_ready"},  int'(bus.cmd_ready), 0);
        chk({tag, "_rsp_valid"},  int'(bus.rsp_valid), 0);
        chk({tag, "_rsp_fields"}, int'({bus.rsp_hit, bus.rsp_min, bus.rsp_max, bus.rsp_count}), 0);
        chk({tag, "_cam_pins"},   int'({bus.cam_init, bus.cam_setD, bus.cam_lookup, bus.cam_newD}), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_key   = 4'h0;
        bus.cmd_data  = 4'h0;
        bus.rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset");
        reset = 1'b0;
        @(posedge clk);
        #1 chk("ready_after_reset", int'(bus.cmd_ready), 1);

        // INIT, searches, REPLACE miss
        cmd(2'b11, 4'h0, 4'h0, mk(0, 0, 0, 0, 2, 0, 1, 0));
        cmd(2'b00, 4'hA, 4'h0, mk(1, 2, 2, 0, 2, 0, 0, 0));
        cmd(2'b00, 4'h0, 4'h0, mk(0, 0, 0, 0, 2, 0, 0, 0));
        cmd(2'b01, 4'h0, 4'h5, mk(0, 0, 0, 0, 2, 0, 0, 5));
        cmd(2'b00, 4'hA, 4'h0, mk(1, 2, 2, 0, 2, 0, 0, 0));

        // REPLACE hit, then confirm the write
        cmd(2'b11, 4'h0, 4'h0, mk(0, 0, 0, 0, 2, 0, 1, 0));
        cmd(2'b01, 4'hA, 4'h3, mk(1, 2, 2, 1, 3, 1, 0, 3));
        cmd(2'b00, 4'h3, 4'h0, mk(1, 2, 2, 0, 2, 0, 0, 0));

        // Build entries 0,1,4 = 8, then REPLACE_ALL 8 -> 5
        cmd(2'b11, 4'h0, 4'h0, mk(0, 0, 0, 0, 2, 0, 1, 0));
        cmd(2'b01, 4'h9, 4'h8, mk(1, 1, 1, 1, 3, 1, 0, 8));
        cmd(2'b01, 4'hC, 4'h8, mk(1, 4, 4, 1, 3, 1, 0, 8));
        cmd(2'b10, 4'h8, 4'h5, mk(1, 0, 4, 3, 6, 2, 0, 5));
        cmd(2'b00, 4'h8, 4'h0, mk(0, 0, 0, 0, 2, 0, 0, 0));
        cmd(2'b00, 4'h5, 4'h0, mk(1, 0, 4, 0, 2, 0, 0, 0));

        // REPLACE_ALL with data == key must not write
        cmd(2'b11, 4'h0, 4'h0, mk(0, 0, 0, 0, 2, 0, 1, 0));
        cmd(2'b10, 4'h8, 4'h8, mk(1, 0, 0, 0, 2, 0, 0, 8));

        // Backpressure: hold the response, offer a command that must be ignored
        bus.rsp_ready = 1'b0;
        issue(2'b00, 4'hB, 4'h0, mk(1, 3, 3, 0, 2, 0, 0, 0));
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_rsp_seen", int'(bus.rsp_valid), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_cmd_ready", int'(bus.cmd_ready), 0);
            chk("bp_rsp_valid", int'(bus.rsp_valid), 1);
            chk("bp_cam_init",  int'(bus.cam_init), 0);
        end
        @(posedge clk);
        #2;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        wait_idle();
        cmd(2'b00, 4'hB, 4'h0, mk(1, 3, 3, 0, 2, 0, 0, 0));

        // Reset during WRITE of a REPLACE_ALL
        issue(2'b10, 4'hA, 4'h3, mk(1, 2, 2, 1, 4, 1, 0, 3));
        n = 0;
        while (!bus.cam_setD && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_in_write", int'(bus.cam_setD), 1);
        reset = 1'b1;
        @(posedge clk);
        #1 chk_all_zero("midreset");
        sb.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_reset_setD",     int'(bus.cam_setD), 0);
            chk("post_reset_rsp_valid", int'(bus.rsp_valid), 0);
        end
        chk("post_reset_ready", int'(bus.cmd_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
